uart_msg_assembler: RTL and testbench

Parametrised successor to the fixed 76-byte UART message receiver. Consumes the byte stream from async_receiver (byte_valid/byte_in) and packs NUM_BYTES bytes MSB-first into a wide message register. It then presents the message to the hash core with a valid/ready handshake. Adds behaviour the fixed receiver lacks:
- configurable length, with no throw-away trailer byte;
- an inter-byte timeout that resynchronises a broken frame;
- back-pressure with sticky overflow detection;
- proper asynchronous reset.

---
 rtl/uart_msg_assembler.sv | 98 +++++++++
 tb/tb_uart_msg_assembler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_assembler.sv
// Packs a UART byte stream MSB-first into a NUM_BYTES message and hands it on with valid/ready.
// Adds an inter-byte timeout for resync and a sticky overflow flag for bytes dropped while holding.
module uart_msg_assembler #(
  parameter int                     NUM_BYTES      = 76,
  parameter int                     TIMEOUT_CYCLES = 1000000,
  parameter logic [NUM_BYTES*8-1:0] INIT_VALUE     = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             byte_valid,
  input  logic [7:0]                       byte_in,
  input  logic                             msg_ready,
  input  logic                             overflow_clr,
  output logic [NUM_BYTES*8-1:0]           data_out,
  output logic                             msg_valid,
  output logic [$clog2(NUM_BYTES+1)-1:0]   byte_count,
  output logic                             frame_timeout,
  output logic                             overflow
);

  localparam int CW = $clog2(NUM_BYTES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST_IDX   = CW'(NUM_BYTES - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(NUM_BYTES);
  // The timer never holds TIMEOUT_CYCLES itself: the expiring increment is replaced by the resync.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= COLLECT;
      data_out      <= INIT_VALUE;
      msg_valid     <= 1'b0;
      byte_count    <= '0;
      frame_timeout <= 1'b0;
      overflow      <= 1'b0;
      timer         <= '0;
    end else begin
      frame_timeout <= 1'b0;
      // Clear first so a coincident overflow event below takes precedence.
      if (overflow_clr) overflow <= 1'b0;

      case (state)
        COLLECT: begin
          if (byte_valid) begin
            for (int unsigned k = 0; k < NUM_BYTES; k++) begin
              if (byte_count == CW'(k)) data_out[(NUM_BYTES-1-k)*8 +: 8] <= byte_in;
            end
            timer <= '0;
            if (byte_count == LAST_IDX) begin
              state      <= HOLD;
              msg_valid  <= 1'b1;
              byte_count <= FULL_COUNT;
            end else begin
              byte_count <= byte_count + CW'(1);
            end
          end else if (TIMEOUT_CYCLES > 0 && byte_count != '0) begin
            if (timer == TIMER_LAST) begin
              timer         <= '0;
              byte_count    <= '0;
              frame_timeout <= 1'b1;
            end else begin
              timer <= timer + TW'(1);
            end
          end else begin
            timer <= '0;
          end
        end

        HOLD: begin
          timer <= '0;
          if (msg_ready) begin
            state     <= COLLECT;
            msg_valid <= 1'b0;
            if (byte_valid) begin
              data_out[NUM_BYTES*8-1 -: 8] <= byte_in;
              byte_count                   <= CW'(1);
            end else begin
              byte_count <= '0;
            end
          end else if (byte_valid) begin
            overflow <= 1'b1;
          end
        end

        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_msg_assembler.sv
// Directed bench: a 4-byte instance driven from a vector table plus hand sequences,
// and a 76-byte instance streamed at a slow byte rate.
module tb_uart_msg_assembler;

  logic clk;
  logic rst_n;

  logic        bv_a, rdy_a, clr_a;
  logic [7:0]  bi_a;
  logic [31:0] data_a;
  logic        vld_a, ft_a, ovf_a;
  logic [2:0]  cnt_a;

  logic         bv_b;
  logic [7:0]   bi_b;
  logic         rdy_b, clr_b;
  logic [607:0] data_b;
  logic         vld_b, ft_b, ovf_b;
  logic [6:0]   cnt_b;

  int checks;
  int failures;

  uart_msg_assembler #(
    .NUM_BYTES(4),
    .TIMEOUT_CYCLES(16),
    .INIT_VALUE(32'hDEADBEEF)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .byte_valid(bv_a), .byte_in(bi_a), .msg_ready(rdy_a), .overflow_clr(clr_a),
    .data_out(data_a), .msg_valid(vld_a), .byte_count(cnt_a),
    .frame_timeout(ft_a), .overflow(ovf_a)
  );

  uart_msg_assembler #(
    .NUM_BYTES(76)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .byte_valid(bv_b), .byte_in(bi_b), .msg_ready(rdy_b), .overflow_clr(clr_b),
    .data_out(data_b), .msg_valid(vld_b), .byte_count(cnt_b),
    .frame_timeout(ft_b), .overflow(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        bv;
    logic [7:0]  b;
    logic        rdy;
    logic        clr;
    logic [31:0] data;
    logic        vld;
    logic [2:0]  cnt;
    logic        ovf;
  } vec_t;

  vec_t vecs[17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [607:0] act, input logic [607:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] b);
    bv_a = 1'b1;
    bi_a = b;
    step();
    bv_a = 1'b0;
  endtask

  logic [607:0] exp_b;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    bv_a = 1'b0; bi_a = '0; rdy_a = 1'b0; clr_a = 1'b0;
    bv_b = 1'b0; bi_b = '0; rdy_b = 1'b0; clr_b = 1'b0;

    //               bv    byte   rdy   clr   data           vld   cnt   ovf
    vecs[0]  = '{1'b1, 8'h61, 1'b0, 1'b0, 32'h61ADBEEF, 1'b0, 3'd1, 1'b0};
    vecs[1]  = '{1'b1, 8'h62, 1'b0, 1'b0, 32'h6162BEEF, 1'b0, 3'd2, 1'b0};
    vecs[2]  = '{1'b1, 8'h63, 1'b0, 1'b0, 32'h616263EF, 1'b0, 3'd3, 1'b0};
    vecs[3]  = '{1'b1, 8'h64, 1'b0, 1'b0, 32'h61626364, 1'b1, 3'd4, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 32'h61626364, 1'b1, 3'd4, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 32'h61626364, 1'b1, 3'd4, 1'b0};
    vecs[6]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 32'h61626364, 1'b1, 3'd4, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 32'h61626364, 1'b1, 3'd4, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 32'h61626364, 1'b1, 3'd4, 1'b0};
    vecs[9]  = '{1'b1, 8'hBB, 1'b0, 1'b1, 32'h61626364, 1'b1, 3'd4, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 32'h61626364, 1'b1, 3'd4, 1'b0};
    vecs[11] = '{1'b1, 8'h55, 1'b1, 1'b0, 32'h55626364, 1'b0, 3'd1, 1'b0};
    vecs[12] = '{1'b1, 8'h56, 1'b0, 1'b0, 32'h55566364, 1'b0, 3'd2, 1'b0};
    vecs[13] = '{1'b1, 8'h57, 1'b0, 1'b0, 32'h55565764, 1'b0, 3'd3, 1'b0};
    vecs[14] = '{1'b1, 8'h58, 1'b0, 1'b0, 32'h55565758, 1'b1, 3'd4, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 32'h55565758, 1'b0, 3'd0, 1'b0};
    vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 32'h55565758, 1'b0, 3'd0, 1'b0};

    step(); step();
    chk("rst_data", 608'(data_a), 608'(32'hDEADBEEF));
    chk("rst_valid", 608'(vld_a), 608'(1'b0));
    chk("rst_count", 608'(cnt_a), 608'(3'd0));
    chk("rst_timeout", 608'(ft_a), 608'(1'b0));
    chk("rst_overflow", 608'(ovf_a), 608'(1'b0));
    chk("rst_data_b", data_b, '0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 17; i++) begin
      bv_a = vecs[i].bv; bi_a = vecs[i].b; rdy_a = vecs[i].rdy; clr_a = vecs[i].clr;
      step();
      bv_a = 1'b0; rdy_a = 1'b0; clr_a = 1'b0;
      chk($sformatf("v%0d_data", i), 608'(data_a), 608'(vecs[i].data));
      chk($sformatf("v%0d_valid", i), 608'(vld_a), 608'(vecs[i].vld));
      chk($sformatf("v%0d_count", i), 608'(cnt_a), 608'(vecs[i].cnt));
      chk($sformatf("v%0d_overflow", i), 608'(ovf_a), 608'(vecs[i].ovf));
    end

    // Timeout after 16 idle cycles with a partial frame.
    send_a(8'h11);
    send_a(8'h22);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk($sformatf("to1_idle%0d_pulse", k), 608'(ft_a), 608'(1'b0));
    end
    chk("to1_count_before", 608'(cnt_a), 608'(3'd2));
    step();
    chk("to1_pulse", 608'(ft_a), 608'(1'b1));
    chk("to1_count", 608'(cnt_a), 608'(3'd0));
    chk("to1_data_kept", 608'(data_a), 608'(32'h11225758));
    step();
    chk("to1_pulse_end", 608'(ft_a), 608'(1'b0));

    // A byte in the expiring cycle is accepted and cancels the timeout.
    send_a(8'h33);
    repeat (15) step();
    send_a(8'h44);
    chk("to2_rescue_pulse", 608'(ft_a), 608'(1'b0));
    chk("to2_rescue_count", 608'(cnt_a), 608'(3'd2));
    repeat (15) step();
    chk("to2_count_before", 608'(cnt_a), 608'(3'd2));
    step();
    chk("to2_pulse", 608'(ft_a), 608'(1'b1));
    chk("to2_count", 608'(cnt_a), 608'(3'd0));
    chk("to2_data_kept", 608'(data_a), 608'(32'h33445758));

    send_a(8'hA1); send_a(8'hA2); send_a(8'hA3); send_a(8'hA4);
    chk("a_frame_data", 608'(data_a), 608'(32'hA1A2A3A4));
    chk("a_frame_valid", 608'(vld_a), 608'(1'b1));
    repeat (20) step();
    chk("hold_no_timeout", 608'(ft_a), 608'(1'b0));
    chk("hold_still_valid", 608'(vld_a), 608'(1'b1));
    chk("hold_count", 608'(cnt_a), 608'(3'd4));
    rdy_a = 1'b1;
    step();
    rdy_a = 1'b0;
    chk("drain_valid", 608'(vld_a), 608'(1'b0));

    // Asynchronous reset mid-frame, asserted away from any clock edge.
    send_a(8'hC1); send_a(8'hC2); send_a(8'hC3);
    chk("pre_rst_count", 608'(cnt_a), 608'(3'd3));
    rst_n = 1'b0;
    #2;
    chk("mid_rst_data", 608'(data_a), 608'(32'hDEADBEEF));
    chk("mid_rst_count", 608'(cnt_a), 608'(3'd0));
    chk("mid_rst_valid", 608'(vld_a), 608'(1'b0));
    step();
    rst_n = 1'b1;
    send_a(8'h01); send_a(8'h02); send_a(8'h03); send_a(8'h04);
    chk("post_rst_data", 608'(data_a), 608'(32'h01020304));
    chk("post_rst_valid", 608'(vld_a), 608'(1'b1));

    // 76-byte frame at a slow byte rate.
    exp_b = '0;
    for (int i = 0; i < 76; i++) begin
      exp_b[(75-i)*8 +: 8] = 8'(i + 1);
      bv_b = 1'b1;
      bi_b = 8'(i + 1);
      step();
      bv_b = 1'b0;
      if (i == 74) begin
        chk("b_count75", 608'(cnt_b), 608'(7'd75));
        chk("b_valid_early", 608'(vld_b), 608'(1'b0));
      end
      if (i < 75) repeat (49) step();
    end
    chk("b_valid", 608'(vld_b), 608'(1'b1));
    chk("b_count76", 608'(cnt_b), 608'(7'd76));
    chk("b_data", data_b, exp_b);
    chk("b_no_timeout", 608'(ft_b), 608'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
